// File: rtl/dmux_1xn_decode.sv
`default_nettype none
// ============================================================================
// Module   : dmux_1xn_decode
// Purpose  : Combinational binary-to-one-hot decoder for an N-line demux.
//            o_valid is high when i_sel addresses an existing line (< N).
// Revision : 1.0 - initial release
// ============================================================================
module dmux_1xn_decode #(
  parameter int N = 8
) (
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_sel,
  output logic [N-1:0]                         o_onehot,
  output logic                                 o_valid
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  // One-hot decode; indices >= N simply match no line, so the result is zero
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = (i_sel == SW'(i));
    end
  end

  // With a power-of-two N every Sel code maps to a line; otherwise the top
  // codes are unused and must be flagged.
  generate
    if (N == (1 << SW)) begin : g_full_range
      assign o_valid = 1'b1;
    end else begin : g_partial_range
      localparam logic [SW-1:0] c_n = SW'(N);
      assign o_valid = (i_sel < c_n);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dmux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : dmux_1xn
// Purpose  : Registered 1-to-N demultiplexer. Steers D to Y[Sel] one clock
//            later; all other lines are 0. sel_err flags an out-of-range Sel.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_1xn #(
  parameter int N = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 D,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] Sel,
  output logic [N-1:0]                         Y,
  output logic                                 sel_err
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] w_onehot;
  logic         w_valid;
  logic [N-1:0] w_y_next;

  dmux_1xn_decode #(
    .N (N)
  ) u_decode (
    .i_sel    (Sel),
    .o_onehot (w_onehot),
    .o_valid  (w_valid)
  );

  // An invalid Sel decodes to all zeros, so no line is driven in that case
  assign w_y_next = w_onehot & {N{D}};

  // Output register: reset clears both outputs, otherwise capture every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      Y       <= '0;
      sel_err <= 1'b0;
    end else begin
      Y       <= w_y_next;
      sel_err <= ~w_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmux_1xn.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_1xn
// Purpose  : Self-checking bench for dmux_1xn with N=8 and N=5 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmux_1xn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d8 = 1'b0;
  logic [2:0] sel8 = '0;
  logic [7:0] y8;
  logic       err8;
  logic       d5 = 1'b0;
  logic [2:0] sel5 = '0;
  logic [4:0] y5;
  logic       err5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmux_1xn #(.N(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .D       (d8),
    .Sel     (sel8),
    .Y       (y8),
    .sel_err (err8)
  );

  dmux_1xn #(.N(5)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .D       (d5),
    .Sel     (sel5),
    .Y       (y5),
    .sel_err (err5)
  );

  // Reference: line Sel gets D if Sel names a real line; nothing otherwise
  function automatic logic [7:0] ref_y(int n, bit d, int sel);
    if (d && sel < n) return 8'(1 << sel);
    return 8'd0;
  endfunction

  function automatic bit ref_err(int n, int sel);
    return (sel >= n);
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs, clock once, then check both instances
  task automatic cyc(string tag, bit r, bit dd8, int s8, bit dd5, int s5);
    logic [7:0] e8, e5;
    bit ee8, ee5;
    @(negedge clk);
    rst  = r;
    d8   = dd8;
    sel8 = s8[2:0];
    d5   = dd5;
    sel5 = s5[2:0];
    @(posedge clk);
    #1;
    e8  = r ? 8'd0 : ref_y(8, dd8, s8);
    ee8 = r ? 1'b0 : ref_err(8, s8);
    e5  = r ? 8'd0 : ref_y(5, dd5, s5);
    ee5 = r ? 1'b0 : ref_err(5, s5);
    check({tag, " n8 y"},   y8, e8);
    check({tag, " n8 err"}, {7'd0, err8}, {7'd0, ee8});
    check({tag, " n5 y"},   {3'd0, y5}, e5);
    check({tag, " n5 err"}, {7'd0, err5}, {7'd0, ee5});
    check({tag, " n8 onehot"}, ($countones(y8) <= 1) ? 8'd1 : 8'd0, 8'd1);
    check({tag, " n5 onehot"}, ($countones(y5) <= 1) ? 8'd1 : 8'd0, 8'd1);
  endtask

  initial begin
    // Reset held two cycles while inputs would otherwise drive a line
    cyc("reset0", 1'b1, 1'b1, 3, 1'b1, 3);
    cyc("reset1", 1'b1, 1'b1, 3, 1'b1, 3);
    cyc("post_reset", 1'b0, 1'b1, 3, 1'b1, 3);
    check("post_reset literal", y8, 8'b00001000);

    // Full sweep; the N=5 instance also sees its out-of-range codes
    for (int s = 0; s < 8; s++) cyc("sweep", 1'b0, 1'b1, s, 1'b1, s);

    // D=0 gives all-zero Y without an error flag
    cyc("data_zero", 1'b0, 1'b0, 5, 1'b0, 2);
    check("data_zero literal", y8, 8'b00000000);
    cyc("data_one", 1'b0, 1'b1, 5, 1'b1, 2);
    check("data_one literal", y8, 8'b00100000);

    // N=5 boundary and out-of-range codes, then recovery
    cyc("n5_top", 1'b0, 1'b1, 4, 1'b1, 4);
    check("n5_top literal", {3'd0, y5}, 8'b00010000);
    for (int s = 5; s < 8; s++) begin
      cyc("n5_oor", 1'b0, 1'b1, s, 1'b1, s);
      check("n5_oor err literal", {7'd0, err5}, 8'd1);
    end
    cyc("n5_back", 1'b0, 1'b1, 0, 1'b1, 0);
    check("n5_back literal", {3'd0, y5}, 8'b00000001);

    // Mid-operation reset pulse
    cyc("pre_rst", 1'b0, 1'b1, 6, 1'b1, 6);
    cyc("mid_rst", 1'b1, 1'b1, 6, 1'b1, 6);
    check("mid_rst literal", y8, 8'b00000000);
    cyc("after_rst", 1'b0, 1'b1, 6, 1'b1, 6);
    check("after_rst literal", y8, 8'b01000000);

    // Random traffic on both instances
    for (int k = 0; k < 1000; k++) begin
      cyc("random", 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    // Occasional random resets mixed into traffic
    for (int k = 0; k < 100; k++) begin
      cyc("random_rst", ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
